// File: rtl/player_motion_ctl_pkg.sv
// Shared court geometry and motion constants for the blob motion controllers.
// player2 reuses the coordinate width and court limits with a mirrored X range.
package player_motion_ctl_pkg;

  localparam int unsigned COORD_W = 12;

  localparam logic [COORD_W-1:0] X_MIN_DEF    = 12'd16;
  localparam logic [COORD_W-1:0] X_MAX_DEF    = 12'd432;
  localparam logic [COORD_W-1:0] X_START_DEF  = 12'd200;
  localparam logic [COORD_W-1:0] Y_TOP_DEF    = 12'd64;
  localparam logic [COORD_W-1:0] Y_GROUND_DEF = 12'd620;

  localparam logic [3:0]        STEP_X_DEF  = 4'd6;
  localparam logic signed [7:0] JUMP_V0_DEF = 8'sd24;
  localparam logic signed [7:0] GRAVITY_DEF = 8'sd1;

  // Jump FSM encoding kept identical to the legacy localparam values.
  typedef enum logic [0:0] {
    ST_GROUND = 1'b0,
    ST_AIR    = 1'b1
  } motion_state_t;

  // Signed 8-bit add clamped to [-128, +127].
  function automatic logic signed [7:0] sat_add_vel(input logic signed [7:0] v,
                                                    input logic signed [7:0] g);
    logic signed [8:0] s;
    s = {v[7], v} + {g[7], g};
    if (s > 9'sd127)       return 8'sd127;
    else if (s < -9'sd128) return -8'sd128;
    else                   return s[7:0];
  endfunction

endpackage

// File: rtl/player_motion_ctl_btn_sync.sv
// btn_sync: N-bit two-flop synchroniser for asynchronous button inputs.
//  clk  in  1      sampling clock
//  rst  in  1      synchronous, active-high reset (clears both stages)
//  d    in  WIDTH  asynchronous inputs
//  q    out WIDTH  synchronised outputs (two clk latency)
module btn_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/player_motion_ctl.sv
// player_motion_ctl: once-per-frame motion controller for one blob sprite.
// Position, velocity and jump state update only on the cycle where vblnk_in
// rises, so the sprite never moves mid-scan.
//  pclk       in   1   pixel clock
//  rst        in   1   synchronous, active-high reset
//  vblnk_in   in   1   vertical blank from the timing generator
//  btn_left   in   1   async button, active-high
//  btn_right  in   1   async button, active-high
//  btn_jump   in   1   async button, active-high
//  xpos       out  12  sprite top-left x
//  ypos       out  12  sprite top-left y
//  in_air     out  1   high while the jump FSM is airborne
//  frame_tick out  1   one-cycle pulse on the cycle after an update
module player_motion_ctl
  import player_motion_ctl_pkg::*;
#(
  parameter logic [11:0]        X_MIN    = X_MIN_DEF,
  parameter logic [11:0]        X_MAX    = X_MAX_DEF,
  parameter logic [11:0]        X_START  = X_START_DEF,
  parameter logic [11:0]        Y_TOP    = Y_TOP_DEF,
  parameter logic [11:0]        Y_GROUND = Y_GROUND_DEF,
  parameter logic [3:0]         STEP_X   = STEP_X_DEF,
  parameter logic signed [7:0]  JUMP_V0  = JUMP_V0_DEF,
  parameter logic signed [7:0]  GRAVITY  = GRAVITY_DEF
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        in_air,
  output logic        frame_tick
);

  logic [2:0]        btn_s;
  logic              vblnk_d;
  logic              tick;
  logic              left, right, jump;
  motion_state_t     state, state_next;
  logic signed [7:0] vel, vel_next;
  logic [11:0]       x_next, y_next;
  logic signed [12:0] nx_l, nx_r, ny;

  btn_sync #(.WIDTH(3)) u_btn_sync (
    .clk (pclk),
    .rst (rst),
    .d   ({btn_jump, btn_right, btn_left}),
    .q   (btn_s)
  );

  assign left  = btn_s[0];
  assign right = btn_s[1];
  assign jump  = btn_s[2];
  assign tick  = vblnk_in & ~vblnk_d;

  // Horizontal step, evaluated in 13-bit signed so a step past either edge
  // cannot wrap before it is clamped.
  always_comb begin
    x_next = xpos;
    nx_l   = $signed({1'b0, xpos}) - $signed({9'd0, STEP_X});
    nx_r   = $signed({1'b0, xpos}) + $signed({9'd0, STEP_X});
    if (left && !right)
      x_next = (nx_l < $signed({1'b0, X_MIN})) ? X_MIN : nx_l[11:0];
    else if (right && !left)
      x_next = (nx_r > $signed({1'b0, X_MAX})) ? X_MAX : nx_r[11:0];
  end

  // Jump FSM with constant gravity; downward is positive velocity.
  always_comb begin
    y_next     = ypos;
    vel_next   = vel;
    state_next = state;
    ny         = $signed({1'b0, ypos}) + $signed({{5{vel[7]}}, vel});
    case (state)
      ST_GROUND: begin
        if (jump) begin
          vel_next   = -JUMP_V0;
          state_next = ST_AIR;
        end else begin
          y_next   = Y_GROUND;
          vel_next = '0;
        end
      end
      default: begin
        if (ny >= $signed({1'b0, Y_GROUND})) begin
          y_next     = Y_GROUND;
          vel_next   = '0;
          state_next = ST_GROUND;
        end else if (ny < $signed({1'b0, Y_TOP})) begin
          y_next   = Y_TOP;
          vel_next = '0;
        end else begin
          y_next   = ny[11:0];
          vel_next = sat_add_vel(vel, GRAVITY);
        end
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_d    <= 1'b0;
      frame_tick <= 1'b0;
      xpos       <= X_START;
      ypos       <= Y_GROUND;
      vel        <= '0;
      state      <= ST_GROUND;
      in_air     <= 1'b0;
    end else begin
      vblnk_d    <= vblnk_in;
      frame_tick <= tick;
      if (tick) begin
        xpos   <= x_next;
        ypos   <= y_next;
        vel    <= vel_next;
        state  <= state_next;
        in_air <= (state_next == ST_AIR);
      end
    end
  end

endmodule

// File: tb/tb_player_motion_ctl.sv
module tb_player_motion_ctl;

  logic        pclk = 1'b0;
  logic        rst, vblnk_in, btn_left, btn_right, btn_jump;
  logic [11:0] xpos, ypos, xpos2, ypos2;
  logic        in_air, frame_tick, in_air2, frame_tick2;

  always #5 pclk = ~pclk;

  player_motion_ctl dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .xpos(xpos), .ypos(ypos), .in_air(in_air), .frame_tick(frame_tick)
  );

  // Second instance with a low ceiling to exercise the Y_TOP clamp.
  player_motion_ctl #(.Y_TOP(12'd600)) dut_top (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .xpos(xpos2), .ypos(ypos2), .in_air(in_air2), .frame_tick(frame_tick2)
  );

  typedef struct {
    int unsigned x;
    int unsigned y;
    bit          air;
  } exp_t;

  typedef struct {
    bit          l, r, j;
    int unsigned x, y;
    bit          air;
  } vec_t;

  exp_t sb[$];
  int   n_pass = 0, n_total = 0;
  int   tick_count = 0;
  bit   chk_en = 1'b0, chk_stable = 1'b0;
  int   prev_x, prev_y;

  // Reference model state
  int m_x, m_y, m_v;
  bit m_air;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_x = 200; m_y = 620; m_v = 0; m_air = 1'b0;
  endtask

  task automatic model_step(input bit l, input bit r, input bit j);
    int ny;
    exp_t e;
    if (l && !r)      m_x = (m_x - 6 < 16)  ? 16  : m_x - 6;
    else if (r && !l) m_x = (m_x + 6 > 432) ? 432 : m_x + 6;
    if (!m_air) begin
      if (j) begin m_v = -24; m_air = 1'b1; end
      else begin m_y = 620; m_v = 0; end
    end else begin
      ny = m_y + m_v;
      if (ny >= 620)    begin m_y = 620; m_v = 0; m_air = 1'b0; end
      else if (ny < 64) begin m_y = 64; m_v = 0; end
      else begin m_y = ny; m_v = (m_v + 1 > 127) ? 127 : m_v + 1; end
    end
    e.x = m_x; e.y = m_y; e.air = m_air;
    sb.push_back(e);
  endtask

  // Buttons settle through the synchroniser, then a one-cycle vblank pulse.
  task automatic drive_frame(input bit l, input bit r, input bit j);
    btn_left = l; btn_right = r; btn_jump = j;
    repeat (3) @(negedge pclk);
    vblnk_in = 1'b1;
    @(negedge pclk);
    vblnk_in = 1'b0;
    repeat (3) @(negedge pclk);
  endtask

  task automatic frame(input bit l, input bit r, input bit j);
    model_step(l, r, j);
    drive_frame(l, r, j);
  endtask

  task automatic do_reset();
    chk_stable = 1'b0;
    btn_left = 0; btn_right = 0; btn_jump = 0; vblnk_in = 0;
    rst = 1'b1;
    @(negedge pclk);
    check("rst_xpos", int'(xpos), 200);
    check("rst_ypos", int'(ypos), 620);
    check("rst_in_air", int'(in_air), 0);
    check("rst_frame_tick", int'(frame_tick), 0);
    @(negedge pclk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge pclk);
    chk_stable = 1'b1;
  endtask

  // Scoreboard: pops one expectation per frame_tick; between ticks the
  // position must hold.
  always @(negedge pclk) begin
    if (chk_en) begin
      if (frame_tick) begin
        tick_count++;
        if (sb.size() == 0) check("unexpected_tick", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("frame_xpos", int'(xpos), int'(e.x));
          check("frame_ypos", int'(ypos), int'(e.y));
          check("frame_in_air", int'(in_air), int'(e.air));
        end
      end else if (chk_stable) begin
        check("xpos_stable", int'(xpos), prev_x);
        check("ypos_stable", int'(ypos), prev_y);
      end
    end
    prev_x = int'(xpos);
    prev_y = int'(ypos);
  end

  vec_t vecs[11];
  int   y_top_exp[9] = '{620, 600, 600, 601, 603, 606, 610, 615, 620};
  bit   air_top_exp[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    vecs[0]  = '{0, 0, 0, 200, 620, 0};
    vecs[1]  = '{0, 0, 0, 200, 620, 0};
    vecs[2]  = '{0, 0, 0, 200, 620, 0};
    vecs[3]  = '{0, 1, 0, 206, 620, 0};
    vecs[4]  = '{0, 1, 0, 212, 620, 0};
    vecs[5]  = '{1, 1, 0, 212, 620, 0};
    vecs[6]  = '{1, 0, 0, 206, 620, 0};
    vecs[7]  = '{0, 0, 1, 206, 620, 1};
    vecs[8]  = '{0, 0, 0, 206, 596, 1};
    vecs[9]  = '{0, 0, 0, 206, 573, 1};
    vecs[10] = '{0, 1, 1, 212, 551, 1};

    rst = 1'b1; vblnk_in = 0; btn_left = 0; btn_right = 0; btn_jump = 0;
    repeat (3) @(negedge pclk);
    chk_en = 1'b1;
    do_reset();

    for (int unsigned i = 0; i < 11; i++) begin
      exp_t e;
      e.x = vecs[i].x; e.y = vecs[i].y; e.air = vecs[i].air;
      sb.push_back(e);
      drive_frame(vecs[i].l, vecs[i].r, vecs[i].j);
      if (i == 2) check("idle_tick_count", tick_count, 3);
    end
    m_x = 212; m_y = 551; m_v = -21; m_air = 1'b1;

    // Remaining flight: 49 air frames in total, landing exactly on the ground.
    for (int unsigned i = 0; i < 45; i++) frame(0, 0, 0);
    check("air_before_land", int'(in_air), 1);
    frame(0, 0, 0);
    check("land_ypos", int'(ypos), 620);
    check("land_in_air", int'(in_air), 0);

    // Left to 20, then clamp at the court edge.
    for (int unsigned i = 0; i < 32; i++) frame(1, 0, 0);
    check("xpos_at_20", int'(xpos), 20);
    frame(1, 0, 0);
    check("xpos_clamp_min", int'(xpos), 16);
    frame(1, 0, 0);
    for (int unsigned i = 0; i < 70; i++) frame(0, 1, 0);
    check("xpos_clamp_max", int'(xpos), 432);
    for (int unsigned i = 0; i < 5; i++) frame(1, 1, 0);
    check("xpos_both_held", int'(xpos), 432);

    // Jump held throughout: lands, then relaunches on the following tick.
    for (int unsigned i = 0; i < 52; i++) frame(0, 0, 1);
    for (int unsigned i = 0; i < 60 && m_air; i++) frame(0, 0, 0);

    // Reset mid-air at ypos 510.
    frame(0, 1, 1);
    for (int unsigned i = 0; i < 5; i++) frame(0, 0, 0);
    check("pre_reset_ypos", int'(ypos), 510);
    do_reset();

    // Low-ceiling instance; dut mirrors the same stimulus via the model.
    for (int unsigned i = 0; i < 9; i++) begin
      frame(0, 0, (i == 0));
      check("ytop_ypos", int'(ypos2), y_top_exp[i]);
      check("ytop_in_air", int'(in_air2), int'(air_top_exp[i]));
    end

    // Long vblank gives a single tick.
    begin
      int t0;
      t0 = tick_count;
      model_step(0, 0, 0);
      vblnk_in = 1'b1;
      repeat (1000) @(negedge pclk);
      vblnk_in = 1'b0;
      repeat (3) @(negedge pclk);
      check("held_vblnk_ticks", tick_count - t0, 1);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
